// File: rtl/iref_pwr_seq.sv
// Power-up sequencer for the current-reference block: powers it, holds calibration
// for CAL_CYCLES, then waits up to TIMEOUT cycles for ready and reports DONE or an error code.
module iref_pwr_seq #(
  parameter int unsigned CAL_CYCLES = 8,
  parameter int unsigned TIMEOUT    = 40
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       RDY_IREF,
  output logic       PU_IREF,
  output logic       CAL_IREF,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] ERR,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PWRUP  = 3'd1,
    S_SETTLE = 3'd2,
    S_READY  = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_LOST    = 2'b10
  } err_t;

  typedef struct packed {
    logic pu;
    logic cal;
    logic busy;
    logic done;
    err_t err;
  } ctrl_t;

  // Terminal counts: the counter starts at 0 on entry, so the last cycle sees N-1.
  localparam logic [7:0] CAL_LAST = 8'(CAL_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  ctrl_t      ctrl;

  function automatic ctrl_t decode(input state_t s, input err_t e);
    ctrl_t d;
    d = '0;
    case (s)
      S_PWRUP:  begin d.pu = 1'b1; d.cal = 1'b1; d.busy = 1'b1; end
      S_SETTLE: begin d.pu = 1'b1; d.busy = 1'b1; end
      S_READY:  begin d.pu = 1'b1; d.done = 1'b1; end
      S_FAULT:  d.err = e;
      default:  ;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // NOTE: state, counter and outputs are all updated with non-blocking assignments so
  // every branch reads the pre-edge values; outputs are decoded from the next state here,
  // which keeps them registered yet aligned with STATE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      ctrl  <= '0;
    end else if (STOP) begin
      state <= S_IDLE;
      cnt   <= '0;
      ctrl  <= decode(S_IDLE, ERR_NONE);
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_PWRUP;
            cnt   <= '0;
            ctrl  <= decode(S_PWRUP, ERR_NONE);
          end
        end
        S_PWRUP: begin
          if (cnt == CAL_LAST) begin
            state <= S_SETTLE;
            cnt   <= '0;
            ctrl  <= decode(S_SETTLE, ERR_NONE);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_SETTLE: begin
          // Ready on the final allowed cycle still wins over the timeout.
          if (RDY_IREF) begin
            state <= S_READY;
            cnt   <= '0;
            ctrl  <= decode(S_READY, ERR_NONE);
          end else if (cnt == TO_LAST) begin
            state <= S_FAULT;
            cnt   <= '0;
            ctrl  <= decode(S_FAULT, ERR_TIMEOUT);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_READY: begin
          if (!RDY_IREF) begin
            state <= S_FAULT;
            cnt   <= '0;
            ctrl  <= decode(S_FAULT, ERR_LOST);
          end
        end
        S_FAULT: begin
          if (START) begin
            state <= S_PWRUP;
            cnt   <= '0;
            ctrl  <= decode(S_PWRUP, ERR_NONE);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          ctrl  <= decode(S_IDLE, ERR_NONE);
        end
      endcase
    end
  end

  assign PU_IREF  = ctrl.pu;
  assign CAL_IREF = ctrl.cal;
  assign BUSY     = ctrl.busy;
  assign DONE     = ctrl.done;
  assign ERR      = ctrl.err;
  assign STATE    = state;

endmodule

// File: tb/tb_iref_pwr_seq.sv
// Bench for iref_pwr_seq: four instances with different TIMEOUT values share stimulus;
// a directed table, an async-reset sequence and random traffic are checked against a phase model.
module tb_iref_pwr_seq;

  localparam int CAL = 8;
  localparam int TO_LIST [0:3] = '{40, 21, 20, 10};

  // Expected vectors: {STATE, PU, CAL, BUSY, DONE, ERR}
  localparam logic [8:0] E_I  = {3'd0, 4'b0000, 2'b00};
  localparam logic [8:0] E_P  = {3'd1, 4'b1110, 2'b00};
  localparam logic [8:0] E_S  = {3'd2, 4'b1010, 2'b00};
  localparam logic [8:0] E_R  = {3'd3, 4'b1001, 2'b00};
  localparam logic [8:0] E_FT = {3'd4, 4'b0000, 2'b01};
  localparam logic [8:0] E_FL = {3'd4, 4'b0000, 2'b10};

  localparam int PH_IDLE = 0, PH_PWRUP = 1, PH_SETTLE = 2, PH_READY = 3, PH_FAULT = 4;

  typedef struct packed {
    logic            start;
    logic            stop;
    logic            rdy;
    logic [7:0]      n;
    logic [3:0][8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, rdy;
  logic [8:0] dut_o [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic       pu, cal, busy, done;
    logic [1:0] err;
    logic [2:0] st;
    iref_pwr_seq #(.CAL_CYCLES(CAL), .TIMEOUT(TO_LIST[g])) u_dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .STOP(stop), .RDY_IREF(rdy),
      .PU_IREF(pu), .CAL_IREF(cal), .BUSY(busy), .DONE(done), .ERR(err), .STATE(st)
    );
    assign dut_o[g] = {st, pu, cal, busy, done, err};
  end

  int         m_phase [4];
  int         m_tip   [4];
  logic [1:0] m_err   [4];
  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       tbl [$];

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual {st,pu,cal,busy,done,err}=%03b_%04b_%02b required %03b_%04b_%02b",
               name, got[8:6], got[5:2], got[1:0], exp[8:6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic model_reset(input int g);
    m_phase[g] = PH_IDLE;
    m_tip[g]   = 0;
    m_err[g]   = 2'b00;
  endtask

  // Phase model: m_tip counts completed cycles spent in the current phase.
  task automatic model_step(input int g, input logic s, input logic p, input logic r);
    if (p) begin
      model_reset(g);
    end else begin
      case (m_phase[g])
        PH_IDLE: if (s) begin m_phase[g] = PH_PWRUP; m_tip[g] = 0; end
        PH_PWRUP: begin
          m_tip[g]++;
          if (m_tip[g] == CAL) begin m_phase[g] = PH_SETTLE; m_tip[g] = 0; end
        end
        PH_SETTLE: begin
          m_tip[g]++;
          if (r) m_phase[g] = PH_READY;
          else if (m_tip[g] == TO_LIST[g]) begin m_phase[g] = PH_FAULT; m_err[g] = 2'b01; end
        end
        PH_READY: if (!r) begin m_phase[g] = PH_FAULT; m_err[g] = 2'b10; end
        default: if (s) begin m_phase[g] = PH_PWRUP; m_tip[g] = 0; m_err[g] = 2'b00; end
      endcase
    end
  endtask

  function automatic logic [8:0] model_out(input int g);
    logic pu, cal, busy, done;
    pu   = (m_phase[g] >= PH_PWRUP) && (m_phase[g] <= PH_READY);
    cal  = (m_phase[g] == PH_PWRUP);
    busy = (m_phase[g] == PH_PWRUP) || (m_phase[g] == PH_SETTLE);
    done = (m_phase[g] == PH_READY);
    return {3'(m_phase[g]), pu, cal, busy, done, m_err[g]};
  endfunction

  // NOTE: inputs are captured before the edge and outputs sampled 1 time unit after it,
  // so the bench never races the DUT's flops.
  task automatic cycle();
    logic s, p, r, n;
    s = start; p = stop; r = rdy; n = rst_n;
    @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      if (!n) model_reset(g);
      else    model_step(g, s, p, r);
    end
    #1;
    for (int g = 0; g < 4; g++)
      check($sformatf("model dut%0d @%0t", g, $time), dut_o[g], model_out(g));
  endtask

  function automatic vec_t row(input logic s, input logic p, input logic r, input int n,
                               input logic [8:0] e0, input logic [8:0] e1,
                               input logic [8:0] e2, input logic [8:0] e3);
    vec_t v;
    v.start = s; v.stop = p; v.rdy = r; v.n = 8'(n);
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  initial begin
    // Instance order: TIMEOUT 40, 21, 20, 10. RDY rises on the 21st SETTLE cycle.
    tbl.push_back(row(1, 1, 0, 1,  E_I,  E_I,  E_I,  E_I));
    tbl.push_back(row(0, 0, 0, 2,  E_I,  E_I,  E_I,  E_I));
    tbl.push_back(row(1, 0, 0, 1,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(0, 0, 0, 7,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_S,  E_S,  E_S));
    tbl.push_back(row(0, 0, 0, 9,  E_S,  E_S,  E_S,  E_S));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_S,  E_S,  E_FT));
    tbl.push_back(row(0, 0, 0, 9,  E_S,  E_S,  E_S,  E_FT));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_S,  E_FT, E_FT));
    tbl.push_back(row(0, 0, 1, 1,  E_R,  E_R,  E_FT, E_FT));
    tbl.push_back(row(0, 0, 1, 5,  E_R,  E_R,  E_FT, E_FT));
    tbl.push_back(row(0, 0, 0, 1,  E_FL, E_FL, E_FT, E_FT));
    tbl.push_back(row(0, 0, 0, 2,  E_FL, E_FL, E_FT, E_FT));
    tbl.push_back(row(1, 0, 0, 1,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(0, 0, 0, 7,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_S,  E_S,  E_S));
    tbl.push_back(row(0, 1, 0, 1,  E_I,  E_I,  E_I,  E_I));
    tbl.push_back(row(1, 0, 0, 1,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(1, 0, 0, 7,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(1, 0, 0, 1,  E_S,  E_S,  E_S,  E_S));
    tbl.push_back(row(1, 0, 1, 1,  E_R,  E_R,  E_R,  E_R));
    tbl.push_back(row(1, 0, 1, 4,  E_R,  E_R,  E_R,  E_R));
    tbl.push_back(row(0, 1, 1, 1,  E_I,  E_I,  E_I,  E_I));
    tbl.push_back(row(1, 0, 0, 1,  E_P,  E_P,  E_P,  E_P));
    tbl.push_back(row(0, 0, 0, 8,  E_S,  E_S,  E_S,  E_S));
    tbl.push_back(row(0, 0, 0, 9,  E_S,  E_S,  E_S,  E_S));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_S,  E_S,  E_FT));
    tbl.push_back(row(0, 0, 0, 9,  E_S,  E_S,  E_S,  E_FT));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_S,  E_FT, E_FT));
    tbl.push_back(row(0, 0, 0, 1,  E_S,  E_FT, E_FT, E_FT));
    tbl.push_back(row(0, 0, 0, 18, E_S,  E_FT, E_FT, E_FT));
    tbl.push_back(row(0, 0, 0, 1,  E_FT, E_FT, E_FT, E_FT));
    tbl.push_back(row(1, 1, 0, 1,  E_I,  E_I,  E_I,  E_I));
    tbl.push_back(row(0, 0, 0, 2,  E_I,  E_I,  E_I,  E_I));

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rdy = 1'b0;
    for (int g = 0; g < 4; g++) model_reset(g);
    cycle();
    cycle();
    for (int g = 0; g < 4; g++) check($sformatf("reset dut%0d", g), dut_o[g], E_I);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop; rdy = tbl[i].rdy;
      repeat (int'(tbl[i].n)) cycle();
      for (int g = 0; g < 4; g++)
        check($sformatf("row%0d dut%0d", i, g), dut_o[g], tbl[i].exp[g]);
    end

    // Asynchronous reset in the middle of PWRUP, between clock edges.
    start = 1'b1; stop = 1'b0; rdy = 1'b0;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    check("pre_async_rst dut0", dut_o[0], E_P);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) check($sformatf("async_rst dut%0d", g), dut_o[g], E_I);
    #1 rst_n = 1'b1;
    for (int g = 0; g < 4; g++) model_reset(g);
    repeat (3) cycle();
    check("post_rst_idle dut0", dut_o[0], E_I);
    start = 1'b1;
    cycle();
    check("post_rst_start dut0", dut_o[0], E_P);
    start = 1'b0;

    // Random traffic with a per-segment ready probability.
    for (int seg = 0; seg < 60; seg++) begin
      int rp;
      int len;
      case ($urandom_range(0, 3))
        0:       rp = 0;
        1:       rp = 5;
        2:       rp = 90;
        default: rp = 100;
      endcase
      len = int'($urandom_range(10, 60));
      for (int c = 0; c < len; c++) begin
        start = ($urandom_range(0, 99) < 25);
        stop  = ($urandom_range(0, 99) < 2);
        rdy   = ($urandom_range(0, 99) < rp);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
